mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Moore-style control FSM that sequences the multicycle MIPS DataPath one micro-step per clk cycle.
- Decodes op/funct from the instruction register and drives every DataPath control input.
- Adds single-instruction interrupt injection: fetches one instruction from the interrupt address, then resumes at the un-advanced PC.
- Sits beside DataPath in the CPU top level; its only inputs are the DataPath outputs plus an interrupt request.

Parameters:
- IRQ_EN, 1, 0 disables interrupt injection: irqReq is ignored and irqAck stays 0.
- STATE_W, 4, width of the state register and of the dbgState port.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op  input  6  Instr[31:26] from DataPath.
- funct  input  6  Instr[5:0] from DataPath.
- irqReq  input  1  level interrupt request.
- aluControl  output  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- aluSrcB  output  2  00 bData, 01 const 4, 10 signImm, 11 signImm<<2.
- ALUSrcA  output  1  0 PC, 1 A register.
- PCSource  output  1  0 aluResult, 1 ALUOut.
- isBranch, PCWrite, lorD, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, isInterrupted  output  1 each  DataPath enables and selects.
- irqAck  output  1  one-cycle pulse in the INTFETCH cycle.
- illegalOp  output  1  one-cycle pulse when DECODE sees an unsupported op or funct.
- dbgState  output  STATE_W  current state encoding.

Behaviour:
- Reset: all outputs 0 while rst_n is low; state = RST; inIrq flag = 0.
- Asynchronous assertion of rst_n aborts any instruction mid-flight; a partially applied MemWrite or RegWrite is not replayed.
- Outputs decode only from the state register; no output depends combinationally on op, funct or irqReq.
- Exception: illegalOp and the ALU decode in EXEC use op/funct, which are stable because IRWrite=0 outside fetch.
- Unlisted outputs are 0 in every state. States and asserted controls:
- RST: all 0; next state is FETCH.
- FETCH: lorD=0, IRWrite, ALUSrcA=0, aluSrcB=01, ADD, PCSource=0, PCWrite; next DECODE; clears inIrq.
- INTFETCH: isInterrupted, lorD=0, IRWrite, irqAck; PCWrite=0 so PC is unchanged; sets inIrq; next DECODE.
- DECODE: ALUSrcA=0, aluSrcB=11, ADD (branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - Any other op -> pulse illegalOp and go to NEXT.
- MEMADR: ALUSrcA=1, aluSrcB=10, ADD. Next MEMRD for lw, MEMWR for sw.
- MEMRD: lorD=1; next MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite; next NEXT.
- MEMWR: lorD=1, MemWrite; next NEXT.
- EXEC: ALUSrcA=1, aluSrcB=00, aluControl from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR. Next ALUWB.
  - Any other funct in DECODE -> illegalOp pulse and go to NEXT; no register write.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite; next NEXT.
- BRANCH: ALUSrcA=1, aluSrcB=00, SUB, PCSource=1, isBranch (DataPath gates the PC update with zero); next NEXT.
- ADDIEX: ALUSrcA=1, aluSrcB=10, ADD; next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite; next NEXT.
- NEXT is a virtual transition with no cycle spent:
  - Go to INTFETCH if IRQ_EN && irqReq && !inIrq.
  - Otherwise go to FETCH.
- Latencies: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3; INTFETCH adds its own cycle in place of FETCH.
- irqReq is sampled only at NEXT. A request that drops before then is lost.
- An injected instruction is never itself interrupted (no nesting). irqReq held high yields alternating INTFETCH/FETCH sequences.
- irqReq arriving in RST has no effect; the first instruction after reset is always a normal FETCH.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI.
  - Funct constants.
  - aluControl encodings ALU_ADD/SUB/AND/OR.
  - aluSrcB encodings.
  - The state enum.
- One sub-module, mips_alu_decoder: combinational funct -> {aluControl, legal}, used in EXEC and DECODE.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. All outputs 0 during reset; first cycle is RST, next is FETCH with IRWrite=1, PCWrite=1, aluSrcB=01.
- lw (op=100011): dbgState sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. MEMWB has RegWrite=1, MemtoReg=1, RegDst=0; MemWrite is never asserted.
- R-type sub (op=0, funct=0x22): EXEC has aluControl=01, ALUSrcA=1, aluSrcB=00. ALUWB has RegDst=1, RegWrite=1.
- R-type funct=0x27: one-cycle illegalOp pulse in DECODE, then FETCH; no RegWrite.
- beq: BRANCH has isBranch=1, PCSource=1, aluControl=01, PCWrite=0; 3 cycles total.
- irqReq=1 held during addi:
  - After ADDIWB comes INTFETCH (isInterrupted=1, irqAck=1, PCWrite=0).
  - The injected instruction completes, then a normal FETCH follows even with irqReq still 1.
  - With IRQ_EN=0, INTFETCH never occurs.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU/operand-select codes and the controller state enum.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_INTFETCH = 4'd2,
    S_DECODE   = 4'd3,
    S_MEMADR   = 4'd4,
    S_MEMRD    = 4'd5,
    S_MEMWB    = 4'd6,
    S_MEMWR    = 4'd7,
    S_EXEC     = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_ADDIEX   = 4'd11,
    S_ADDIWB   = 4'd12
  } state_t;

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// R-type funct decoder: maps funct to the ALU operation and flags
// functs the DataPath ALU cannot execute.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [1:0] aluControl,
  output logic       legal
);

  always_comb begin
    aluControl = ALU_ADD;
    legal      = 1'b1;
    case (funct)
      FN_ADD:  aluControl = ALU_ADD;
      FN_SUB:  aluControl = ALU_SUB;
      FN_AND:  aluControl = ALU_AND;
      FN_OR:   aluControl = ALU_OR;
      default: legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS DataPath, with single-instruction
// interrupt injection (fetch from the interrupt vector, PC left unadvanced).
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit          IRQ_EN  = 1'b1,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               irqReq,
  output logic [1:0]         aluControl,
  output logic [1:0]         aluSrcB,
  output logic               ALUSrcA,
  output logic               PCSource,
  output logic               isBranch,
  output logic               PCWrite,
  output logic               lorD,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               isInterrupted,
  output logic               irqAck,
  output logic               illegalOp,
  output logic [STATE_W-1:0] dbgState
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_next_instr;
  logic       r_in_irq;
  logic [1:0] w_alu_ctl;
  logic       w_funct_ok;

  mips_alu_decoder u_alu_dec (
    .funct      (funct),
    .aluControl (w_alu_ctl),
    .legal      (w_funct_ok)
  );

  // "NEXT" costs no cycle: every instruction's last state jumps straight here.
  assign w_next_instr = (IRQ_EN && irqReq && !r_in_irq) ? S_INTFETCH : S_FETCH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RST;
      r_in_irq <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH)
        r_in_irq <= 1'b0;
      else if (r_state == S_INTFETCH)
        r_in_irq <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    aluControl    = ALU_ADD;
    aluSrcB       = SRCB_REG;
    ALUSrcA       = 1'b0;
    PCSource      = 1'b0;
    isBranch      = 1'b0;
    PCWrite       = 1'b0;
    lorD          = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    isInterrupted = 1'b0;
    irqAck        = 1'b0;
    illegalOp     = 1'b0;
    case (r_state)
      S_RST: w_next = S_FETCH;
      S_FETCH: begin
        IRWrite = 1'b1;
        aluSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        w_next  = S_DECODE;
      end
      S_INTFETCH: begin
        isInterrupted = 1'b1;
        IRWrite       = 1'b1;
        irqAck        = 1'b1;
        w_next        = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE: begin
            if (w_funct_ok) begin
              w_next = S_EXEC;
            end else begin
              illegalOp = 1'b1;
              w_next    = w_next_instr;
            end
          end
          OP_BEQ:  w_next = S_BRANCH;
          OP_ADDI: w_next = S_ADDIEX;
          default: begin
            illegalOp = 1'b1;
            w_next    = w_next_instr;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        lorD   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = w_next_instr;
      end
      S_MEMWR: begin
        lorD     = 1'b1;
        MemWrite = 1'b1;
        w_next   = w_next_instr;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        aluControl = w_alu_ctl;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_next   = w_next_instr;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        aluControl = ALU_SUB;
        PCSource   = 1'b1;
        isBranch   = 1'b1;
        w_next     = w_next_instr;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_next   = w_next_instr;
      end
      default: w_next = S_RST;
    endcase
  end

  assign dbgState = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-instruction expected control
// sequences built from the instruction classes, checked every cycle.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluc;
    logic [1:0] srcb;
    logic srca, pcsrc, isb, pcw, lord, memw, m2r, irw, regw, regdst, isint, ack, ill;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       irqReq = 1'b0;

  logic [1:0] aluControl, aluSrcB;
  logic ALUSrcA, PCSource, isBranch, PCWrite, lorD, MemWrite, MemtoReg, IRWrite;
  logic RegWrite, RegDst, isInterrupted, irqAck, illegalOp;
  logic [3:0] dbgState;

  logic [1:0] b_aluControl, b_aluSrcB;
  logic b_ALUSrcA, b_PCSource, b_isBranch, b_PCWrite, b_lorD, b_MemWrite, b_MemtoReg;
  logic b_IRWrite, b_RegWrite, b_RegDst, b_isInterrupted, b_irqAck, b_illegalOp;
  logic [3:0] b_dbgState;

  always #5 clk = ~clk;

  mips_multicycle_control #(.IRQ_EN(1'b1), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .irqReq(irqReq),
    .aluControl(aluControl), .aluSrcB(aluSrcB), .ALUSrcA(ALUSrcA), .PCSource(PCSource),
    .isBranch(isBranch), .PCWrite(PCWrite), .lorD(lorD), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .isInterrupted(isInterrupted), .irqAck(irqAck), .illegalOp(illegalOp),
    .dbgState(dbgState)
  );

  mips_multicycle_control #(.IRQ_EN(1'b0), .STATE_W(4)) dut_noirq (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .irqReq(irqReq),
    .aluControl(b_aluControl), .aluSrcB(b_aluSrcB), .ALUSrcA(b_ALUSrcA),
    .PCSource(b_PCSource), .isBranch(b_isBranch), .PCWrite(b_PCWrite), .lorD(b_lorD),
    .MemWrite(b_MemWrite), .MemtoReg(b_MemtoReg), .IRWrite(b_IRWrite),
    .RegWrite(b_RegWrite), .RegDst(b_RegDst), .isInterrupted(b_isInterrupted),
    .irqAck(b_irqAck), .illegalOp(b_illegalOp), .dbgState(b_dbgState)
  );

  vec_t act;
  assign act = {dbgState, aluControl, aluSrcB, ALUSrcA, PCSource, isBranch, PCWrite,
                lorD, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, isInterrupted,
                irqAck, illegalOp};

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t m_exp = '0;
  logic exp_on = 1'b0;
  logic chk_b = 1'b0;
  logic first = 1'b1;
  logic m_in_irq = 1'b0;
  vec_t cap [0:7];

  always @(negedge clk) begin
    if (exp_on) begin
      n_vec++;
      if (act !== m_exp) begin
        n_bad++;
        $display("FAIL ctl_vec t=%0t got %h want %h", $time, act, m_exp);
      end
    end
    if (chk_b) begin
      n_vec++;
      if (b_irqAck !== 1'b0 || b_isInterrupted !== 1'b0 || b_dbgState === 4'(S_INTFETCH)) begin
        n_bad++;
        $display("FAIL noirq_inject t=%0t got ack=%b int=%b st=%0d want ack=0 int=0 st!=INTFETCH",
                 $time, b_irqAck, b_isInterrupted, b_dbgState);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Expected per-cycle controls for one instruction, starting at its fetch.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic irq_in);
    vec_t q[$];
    vec_t e;
    logic intf;
    logic [1:0] code;
    intf = !first && irqReq && !m_in_irq;
    first = 1'b0;
    m_in_irq = intf;
    e = '0;
    if (intf) begin
      e.st = S_INTFETCH; e.isint = 1'b1; e.irw = 1'b1; e.ack = 1'b1;
    end else begin
      e.st = S_FETCH; e.irw = 1'b1; e.srcb = 2'b01; e.pcw = 1'b1;
    end
    q.push_back(e);
    e = '0; e.st = S_DECODE; e.srcb = 2'b11;
    if (o == 6'b100011 || o == 6'b101011) begin
      q.push_back(e);
      e = '0; e.st = S_MEMADR; e.srca = 1'b1; e.srcb = 2'b10; q.push_back(e);
      if (o == 6'b100011) begin
        e = '0; e.st = S_MEMRD; e.lord = 1'b1; q.push_back(e);
        e = '0; e.st = S_MEMWB; e.m2r = 1'b1; e.regw = 1'b1; q.push_back(e);
      end else begin
        e = '0; e.st = S_MEMWR; e.lord = 1'b1; e.memw = 1'b1; q.push_back(e);
      end
    end else if (o == 6'b000000 && f inside {6'h20, 6'h22, 6'h24, 6'h25}) begin
      q.push_back(e);
      code = (f == 6'h20) ? 2'b00 : (f == 6'h22) ? 2'b01 : (f == 6'h24) ? 2'b10 : 2'b11;
      e = '0; e.st = S_EXEC; e.srca = 1'b1; e.aluc = code; q.push_back(e);
      e = '0; e.st = S_ALUWB; e.regdst = 1'b1; e.regw = 1'b1; q.push_back(e);
    end else if (o == 6'b000100) begin
      q.push_back(e);
      e = '0; e.st = S_BRANCH; e.srca = 1'b1; e.aluc = 2'b01; e.pcsrc = 1'b1; e.isb = 1'b1;
      q.push_back(e);
    end else if (o == 6'b001000) begin
      q.push_back(e);
      e = '0; e.st = S_ADDIEX; e.srca = 1'b1; e.srcb = 2'b10; q.push_back(e);
      e = '0; e.st = S_ADDIWB; e.regw = 1'b1; q.push_back(e);
    end else begin
      e.ill = 1'b1;
      q.push_back(e);
    end
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        op = o; funct = f; irqReq = irq_in;
      end
      m_exp = q[i];
      exp_on = 1'b1;
      #1 cap[i] = act;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    m_exp = '0; m_exp.st = S_RST; exp_on = 1'b1; chk_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      chk("rst_vec", act, 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    run_instr(6'b100011, 6'h00, 1'b0);  // lw
    chk("fetch_irw", cap[0].irw, 1);
    chk("fetch_pcw", cap[0].pcw, 1);
    chk("fetch_srcb", cap[0].srcb, 2'b01);
    chk("lw_wb", {cap[4].regw, cap[4].m2r, cap[4].regdst}, 3'b110);

    run_instr(6'b101011, 6'h00, 1'b0);  // sw
    chk("sw_memw", cap[3].memw, 1);

    run_instr(6'b000000, 6'h22, 1'b0);  // sub
    chk("sub_aluc", cap[2].aluc, 2'b01);
    chk("sub_src", {cap[2].srca, cap[2].srcb}, 3'b100);
    chk("sub_wb", {cap[3].regdst, cap[3].regw}, 2'b11);

    run_instr(6'b000000, 6'h20, 1'b0);
    run_instr(6'b000000, 6'h24, 1'b0);
    chk("and_aluc", cap[2].aluc, 2'b10);
    run_instr(6'b000000, 6'h25, 1'b0);
    chk("or_aluc", cap[2].aluc, 2'b11);

    run_instr(6'b000000, 6'h27, 1'b0);  // nor: unsupported
    chk("ill_funct", cap[1].ill, 1);
    run_instr(6'b000010, 6'h00, 1'b0);  // j: unsupported op
    chk("ill_op", cap[1].ill, 1);
    chk("ill_op_next", cap[0].irw, 1);

    run_instr(6'b000100, 6'h00, 1'b0);  // beq
    chk("beq_ctl", {cap[2].isb, cap[2].pcsrc, cap[2].aluc, cap[2].pcw}, 5'b11010);

    run_instr(6'b001000, 6'h00, 1'b1);  // addi with irq held
    run_instr(6'b000000, 6'h25, 1'b1);
    chk("int_ack", cap[0].ack, 1);
    chk("int_isint", cap[0].isint, 1);
    chk("int_pcw", cap[0].pcw, 0);
    run_instr(6'b100011, 6'h00, 1'b1);
    chk("after_int_fetch", {cap[0].pcw, cap[0].ack}, 2'b10);
    run_instr(6'b001000, 6'h00, 1'b1);
    chk("int_again", cap[0].ack, 1);
    run_instr(6'b101011, 6'h00, 1'b0);
    run_instr(6'b000100, 6'h00, 1'b0);

    // Async reset in the middle of a store, with irq pending through reset.
    @(posedge clk); #1 exp_on = 1'b0; op = 6'b101011;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0; irqReq = 1'b1;
    #1 chk("async_rst", act, 0);
    m_exp = '0; m_exp.st = S_RST; exp_on = 1'b1;
    for (int i = 0; i < 2; i++) begin @(posedge clk); #1; end
    rst_n = 1'b1; first = 1'b1; m_in_irq = 1'b0;

    run_instr(6'b001000, 6'h00, 1'b1);
    chk("post_rst_fetch", {cap[0].pcw, cap[0].ack}, 2'b10);
    run_instr(6'b000100, 6'h00, 1'b0);
    chk("post_rst_int", cap[0].ack, 1);
    run_instr(6'b000000, 6'h20, 1'b0);

    @(posedge clk); #1 exp_on = 1'b0; chk_b = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
